// File: rtl/mdu.sv
// Multiply/divide unit with HI/LO registers and a fixed-latency busy window.
// Optional multiply-accumulate ops are enabled by defining MDU_MADD_EN.
module mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [3:0]  MDUOp,
    input  logic        Start,
    output logic        Busy,
    output logic [31:0] Out
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd9;
    localparam logic [3:0] OP_MADDU = 4'd10;
    localparam logic [3:0] OP_MSUB  = 4'd11;
    localparam logic [3:0] OP_MSUBU = 4'd12;
`endif

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = ($clog2(MAXC) < 1) ? 1 : $clog2(MAXC);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt;
    logic [31:0]   hi, lo;
    logic [3:0]    op_q;
    logic [31:0]   a_q, b_q;
    logic          accept, is_mul, is_div;

    logic        sgn, dsgn;
    logic [63:0] ext_a, ext_b, prod, res;
    logic [31:0] abs_a, abs_b, bdiv, quo, rem;

    assign accept = Start && (state == IDLE);

    always_comb begin
        is_mul = (MDUOp == OP_MULT) || (MDUOp == OP_MULTU);
`ifdef MDU_MADD_EN
        is_mul = is_mul || (MDUOp == OP_MADD) || (MDUOp == OP_MADDU)
              || (MDUOp == OP_MSUB) || (MDUOp == OP_MSUBU);
`endif
        is_div = (MDUOp == OP_DIV) || (MDUOp == OP_DIVU);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept && (is_mul || is_div)) state_nx = BUSY;
            BUSY: if (cnt == '0) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        Busy = (state == BUSY);
        unique case (1'b1)
            (MDUOp == OP_MFHI): Out = hi;
            (MDUOp == OP_MFLO): Out = lo;
            default:            Out = 32'd0;
        endcase
    end

    // Result is formed from the issue-edge snapshot; HI/LO cannot change while busy.
    always_comb begin
        sgn = (op_q == OP_MULT);
`ifdef MDU_MADD_EN
        sgn = sgn || (op_q == OP_MADD) || (op_q == OP_MSUB);
`endif
        ext_a = sgn ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
        ext_b = sgn ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
        prod  = ext_a * ext_b;
        dsgn  = (op_q == OP_DIV);
        abs_a = (dsgn && a_q[31]) ? -a_q : a_q;
        abs_b = (dsgn && b_q[31]) ? -b_q : b_q;
        bdiv  = (abs_b == 32'd0) ? 32'd1 : abs_b;
        quo   = abs_a / bdiv;
        rem   = abs_a % bdiv;
        res   = {hi, lo};
        case (op_q)
            OP_MULT, OP_MULTU: res = prod;
            OP_DIV: if (b_q != 32'd0)
                res = {a_q[31] ? -rem : rem,
                       (a_q[31] ^ b_q[31]) ? -quo : quo};
            OP_DIVU: if (b_q != 32'd0) res = {rem, quo};
`ifdef MDU_MADD_EN
            OP_MADD, OP_MADDU: res = {hi, lo} + prod;
            OP_MSUB, OP_MSUBU: res = {hi, lo} - prod;
`endif
            default: res = {hi, lo};
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hi   <= 32'd0;
            lo   <= 32'd0;
            cnt  <= '0;
            op_q <= 4'd0;
            a_q  <= 32'd0;
            b_q  <= 32'd0;
        end else if (state == BUSY) begin
            if (cnt == '0) {hi, lo} <= res;
            else           cnt <= cnt - 1'b1;
        end else if (accept) begin
            if (is_mul || is_div) begin
                op_q <= MDUOp;
                a_q  <= A;
                b_q  <= B;
                cnt  <= is_div ? CW'(DIV_CYCLES - 1) : CW'(MULT_CYCLES - 1);
            end else if (MDUOp == OP_MTHI) begin
                hi <= A;
            end else if (MDUOp == OP_MTLO) begin
                lo <= A;
            end
        end
    end

endmodule

// File: tb/tb_mdu.sv
// Scoreboard bench for mdu: expected HI/LO queued at issue, compared on completion.
// Covers multiply, divide, move-to, reset abort and the optional MDU_MADD_EN path.
module tb_mdu;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic [3:0]  MDUOp = '0;
    logic        Start = 1'b0;
    logic        Busy;
    logic [31:0] Out;

    int n_checks = 0;
    int n_fail = 0;
    logic [63:0] sb[$];
    logic [31:0] mhi = '0;
    logic [31:0] mlo = '0;

    mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset_n(reset_n), .A(A), .B(B),
        .MDUOp(MDUOp), .Start(Start), .Busy(Busy), .Out(Out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [3:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [63:0] hl);
        longint sp;
        logic [63:0] up;
        int q, r;
        sp = longint'($signed(a)) * longint'($signed(b));
        up = {32'd0, a} * {32'd0, b};
        case (op)
            4'd1: return sp;
            4'd2: return up;
            4'd3: begin
                if (b == 0) return hl;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                    return {32'd0, 32'h8000_0000};
                q = int'(a) / int'(b);
                r = int'(a) % int'(b);
                return {r, q};
            end
            4'd4: return (b == 0) ? hl : {a % b, a / b};
            4'd9:  return hl + sp;
            4'd10: return hl + up;
            4'd11: return hl - sp;
            4'd12: return hl - up;
            default: return hl;
        endcase
    endfunction

    task automatic read_hl(output logic [63:0] hl);
        @(negedge clk);
        MDUOp = 4'd7;
        #1 hl[63:32] = Out;
        MDUOp = 4'd8;
        #1 hl[31:0] = Out;
        MDUOp = 4'd0;
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        @(negedge clk);
        A = a;
        B = b;
        MDUOp = op;
        Start = 1'b1;
        @(posedge clk);
        #1;
        Start = 1'b0;
        MDUOp = 4'd0;
        A = $urandom;
        B = $urandom;
    endtask

    task automatic wait_busy(input string tag, input int exp);
        int n = 0;
        while (Busy === 1'b1 && n < 200) begin
            n++;
            @(posedge clk);
            #1;
        end
        check(tag, 64'(n), 64'(exp));
    endtask

    task automatic finish_op(input string tag, input int cyc,
                             output logic [63:0] hl);
        logic [63:0] exp;
        wait_busy({tag, "_busy"}, cyc);
        read_hl(hl);
        exp = (sb.size() > 0) ? sb.pop_front() : 64'hx;
        check(tag, hl, exp);
        {mhi, mlo} = exp;
    endtask

    task automatic run_op(input string tag, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input int cyc, output logic [63:0] hl);
        sb.push_back(model(op, a, b, {mhi, mlo}));
        issue(op, a, b);
        finish_op(tag, cyc, hl);
    endtask

    task automatic mt(input logic [3:0] op, input logic [31:0] a);
        issue(op, a, 32'd0);
        check("mt_nobusy", 64'(Busy), 64'd0);
        if (op == 4'd5) mhi = a;
        else            mlo = a;
    endtask

    initial begin
        logic [63:0] hl;
        logic [3:0] op;
        logic [31:0] ra, rb;

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(Busy), 64'd0);
        read_hl(hl);
        check("rst_hilo", hl, 64'd0);
        reset_n = 1'b1;

        run_op("mult", 4'd1, 32'hFFFF_FFFE, 32'd3, MC, hl);
        check("mult_k", hl, {32'hFFFF_FFFF, 32'hFFFF_FFFA});
        run_op("multu", 4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MC, hl);
        check("multu_k", hl, {32'hFFFF_FFFE, 32'h0000_0001});
        run_op("div", 4'd3, 32'hFFFF_FFF9, 32'd2, DC, hl);
        check("div_k", hl, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        run_op("div_ovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, DC, hl);
        check("div_ovf_k", hl, {32'd0, 32'h8000_0000});
        run_op("div_nd", 4'd3, 32'd7, 32'hFFFF_FFFE, DC, hl);
        check("div_nd_k", hl, {32'd1, 32'hFFFF_FFFD});

        mt(4'd5, 32'h1234_5678);
        run_op("divu0", 4'd4, 32'd99, 32'd0, DC, hl);
        check("divu0_hi", 64'(hl[63:32]), 64'h1234_5678);

        sb.push_back(model(4'd4, 32'd100, 32'd7, {mhi, mlo}));
        issue(4'd4, 32'd100, 32'd7);
        @(negedge clk);
        Start = 1'b1;
        MDUOp = 4'd5;
        A = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        Start = 1'b0;
        MDUOp = 4'd7;
        #1 check("mfhi_busy", 64'(Out), 64'(mhi));
        MDUOp = 4'd0;
        finish_op("mthi_ign", DC - 1, hl);
        check("mthi_ign_k", hl, {32'd2, 32'd14});

        for (int i = 0; i < 8; i++) begin
            op = 4'(1 + (i % 4));
            ra = $urandom;
            rb = $urandom;
            if (rb == 0) rb = 32'd5;
            run_op("rand", op, ra, rb, (op > 4'd2) ? DC : MC, hl);
        end

        @(negedge clk);
        MDUOp = 4'd13;
        #1 check("out_rsv", 64'(Out), 64'd0);
        MDUOp = 4'd0;
        #1 check("out_none", 64'(Out), 64'd0);

        issue(4'd1, 32'd7, 32'd9);
        @(posedge clk);
        #1;
        @(negedge clk);
        reset_n = 1'b0;
        Start = 1'b1;
        MDUOp = 4'd6;
        A = 32'd55;
        @(posedge clk);
        #1;
        Start = 1'b0;
        MDUOp = 4'd0;
        reset_n = 1'b1;
        check("abort_busy", 64'(Busy), 64'd0);
        sb.delete();
        mhi = '0;
        mlo = '0;
        read_hl(hl);
        check("abort_hilo", hl, 64'd0);
        mt(4'd6, 32'h0000_0BAD);
        read_hl(hl);
        check("post_rst_mtlo", hl, {32'd0, 32'h0000_0BAD});

        mt(4'd6, 32'd5);
        mt(4'd5, 32'd0);
`ifdef MDU_MADD_EN
        run_op("madd", 4'd9, 32'd2, 32'd3, MC, hl);
        check("madd_k", hl, {32'd0, 32'd11});
        run_op("msubu", 4'd12, 32'd4, 32'd4, MC, hl);
        check("msubu_k", hl, {32'hFFFF_FFFF, 32'hFFFF_FFFB});
`else
        issue(4'd9, 32'd2, 32'd3);
        wait_busy("madd_off_busy", 0);
        read_hl(hl);
        check("madd_off", hl, {32'd0, 32'd5});
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule
